// File: rtl/dmem_resp_if.sv
// Request/response bundle between the MEM-stage requester and dmem_resp.
// Latency: none; this is wiring only.
// Backpressure: the requester holds req until it sees stall low.
interface dmem_resp_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        stall;
    logic        err;

    // Requester side (datapath MEM stage)
    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, stall, err
    );

    // Responder side (dmem_resp)
    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, stall, err
    );
endinterface

// File: rtl/dmem_resp.sv
// Multi-cycle word-addressed data memory serving MEM-stage loads and stores.
// Latency: ready/rdata/err arrive LATENCY+1 cycles after req is accepted; LATENCY+2 cycles of occupancy.
// Backpressure: stall is high while a request is pending in IDLE or in flight in WAIT; low in DONE.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses with err and suppress them.
module dmem_resp #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 4     // legal range 1..15
) (
    input  logic         clk,
    input  logic         reset,
    dmem_resp_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    we_q;
    logic [31:0]             wdata_q;
    logic                    mis_q;
    logic                    mis_d;
    logic [31:0]             rdata_q;
    logic                    ready_q;
    logic                    err_q;
    logic                    commit;

    // Storage is deliberately left out of reset; contents are undefined until written.
    logic [31:0]             mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
    // A non-word-aligned byte address is flagged when the request is accepted.
    assign mis_d = (bus.addr[1:0] != 2'b00);
`else
    // Low address bits are ignored; every access is treated as word-aligned.
    assign mis_d = 1'b0;
`endif

    // Store commits on the edge that leaves the last WAIT cycle; a reset in WAIT
    // forces state_q to IDLE immediately, so a cancelled store never lands.
    assign commit = (state_q == WAIT) && (cnt_q == 4'd0) && we_q && !mis_q;

    // Array write port, driven only from the held copies of the request.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Access sequencer: accept and hold the request, count down WAIT, pulse completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        idx_q   <= bus.addr[DEPTH_LOG2+1:2];
                        we_q    <= bus.we;
                        wdata_q <= bus.wdata;
                        mis_q   <= mis_d;
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        err_q   <= mis_q;
                        if (mis_q) begin
                            rdata_q <= 32'd0;
                        end else if (!we_q) begin
                            rdata_q <= mem[idx_q];
                        end
                    end
                end
                DONE: begin
                    // A req still high here is the request just served; drop it.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so a fresh request freezes the pipeline in its first cycle.
    assign bus.stall = ((state_q == IDLE) && bus.req) || (state_q == WAIT);
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three instances at LATENCY 4, 1 and 15.
// Latency: checks completion timing and stall width per access.
// Backpressure: the requester holds req until it observes stall low.
module tb_dmem_resp;

    logic clk;
    logic reset;

    logic [2:0]  req_v;
    logic        we_v;
    logic [31:0] addr_v;
    logic [31:0] wdata_v;

    int          sel;
    logic        stall_s;
    logic        ready_s;
    logic        err_s;
    logic [31:0] rdata_s;

    int checks;
    int errors;

    dmem_resp_if if4  ();
    dmem_resp_if if1  ();
    dmem_resp_if if15 ();

    assign if4.req    = req_v[0];
    assign if4.we     = we_v;
    assign if4.addr   = addr_v;
    assign if4.wdata  = wdata_v;
    assign if1.req    = req_v[1];
    assign if1.we     = we_v;
    assign if1.addr   = addr_v;
    assign if1.wdata  = wdata_v;
    assign if15.req   = req_v[2];
    assign if15.we    = we_v;
    assign if15.addr  = addr_v;
    assign if15.wdata = wdata_v;

    dmem_resp #(.DEPTH_LOG2(6), .LATENCY(4))  u_dut4  (.clk(clk), .reset(reset), .bus(if4));
    dmem_resp #(.DEPTH_LOG2(6), .LATENCY(1))  u_dut1  (.clk(clk), .reset(reset), .bus(if1));
    dmem_resp #(.DEPTH_LOG2(6), .LATENCY(15)) u_dut15 (.clk(clk), .reset(reset), .bus(if15));

    always_comb begin
        stall_s = if4.stall;
        ready_s = if4.ready;
        err_s   = if4.err;
        rdata_s = if4.rdata;
        if (sel == 1) begin
            stall_s = if1.stall;
            ready_s = if1.ready;
            err_s   = if1.err;
            rdata_s = if1.rdata;
        end else if (sel == 2) begin
            stall_s = if15.stall;
            ready_s = if15.ready;
            err_s   = if15.err;
            rdata_s = if15.rdata;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access on instance s, started just after a rising edge (cycle 0).
    // Returns the cycle in which ready was seen (-1 on timeout) and the number
    // of cycles stall was high. With scramble set, addr/wdata change every cycle
    // after the accept cycle.
    task automatic access(input int s, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble,
                          output logic [31:0] rd, output logic e,
                          output int rdy_cyc, output int stall_cnt);
        sel       = s;
        we_v      = w;
        addr_v    = a;
        wdata_v   = d;
        req_v     = 3'b000;
        req_v[s]  = 1'b1;
        rdy_cyc   = -1;
        stall_cnt = 0;
        rd        = 32'hx;
        e         = 1'bx;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (stall_s === 1'b1) stall_cnt++;
            if (ready_s === 1'b1) begin
                rdy_cyc = cyc;
                rd      = rdata_s;
                e       = err_s;
            end
            @(posedge clk);
            #1;
            if (rdy_cyc >= 0) break;
            if (scramble) begin
                addr_v  = $urandom;
                wdata_v = $urandom;
            end
        end
        req_v = 3'b000;
    endtask

    logic [31:0] rd;
    logic        e;
    int          rc;
    int          sc;
    int          pulses;

    initial begin
        checks  = 0;
        errors  = 0;
        sel     = 0;
        reset   = 1'b1;
        req_v   = 3'b000;
        we_v    = 1'b0;
        addr_v  = 32'd0;
        wdata_v = 32'd0;

        // Reset state
        #12;
        check("reset_ready", {31'd0, if4.ready}, 32'd0);
        check("reset_err",   {31'd0, if4.err},   32'd0);
        check("reset_rdata", if4.rdata,          32'd0);
        check("reset_stall_req0", {31'd0, if4.stall}, 32'd0);
        req_v[0] = 1'b1;
        #1;
        check("reset_stall_req1", {31'd0, if4.stall}, 32'd1);
        req_v[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Store then load, LATENCY=4
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, e, rc, sc);
        check("st10_ready_cyc", 32'(rc), 32'd5);
        check("st10_stall_cnt", 32'(sc), 32'd5);
        check("st10_err",       {31'd0, e}, 32'd0);
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, e, rc, sc);
        check("ld10_ready_cyc", 32'(rc), 32'd5);
        check("ld10_stall_cnt", 32'(sc), 32'd5);
        check("ld10_rdata",     rd, 32'hDEADBEEF);
        @(negedge clk);
        check("ready_one_cycle", {31'd0, ready_s}, 32'd0);
        @(negedge clk);
        check("rdata_hold", rdata_s, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Aliasing: 0x100 maps to word 0 with 64 words
        access(0, 1'b1, 32'h100, 32'h12345678, 1'b0, rd, e, rc, sc);
        access(0, 1'b0, 32'h000, 32'h0, 1'b0, rd, e, rc, sc);
        check("alias_rdata", rd, 32'h12345678);

        // Upper address bits ignored
        access(0, 1'b0, 32'hFFFF_F010, 32'h0, 1'b0, rd, e, rc, sc);
        check("upper_bits_rdata", rd, 32'hDEADBEEF);

        // Reset mid-access
        access(0, 1'b1, 32'h20, 32'hAAAA5555, 1'b0, rd, e, rc, sc);
        sel      = 0;
        we_v     = 1'b1;
        addr_v   = 32'h20;
        wdata_v  = 32'h11111111;
        req_v[0] = 1'b1;          // cycle 0: accepted
        @(posedge clk);
        #1;                       // WAIT cycle 1
        @(posedge clk);
        #1;                       // WAIT cycle 2
        reset    = 1'b1;
        req_v    = 3'b000;
        @(negedge clk);
        check("rst_mid_ready", {31'd0, ready_s}, 32'd0);
        check("rst_mid_stall", {31'd0, stall_s}, 32'd0);
        check("rst_mid_rdata", rdata_s, 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready_s !== 1'b0) pulses++;
        end
        check("rst_mid_no_ready", 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
        access(0, 1'b0, 32'h20, 32'h0, 1'b0, rd, e, rc, sc);
        check("rst_mid_rdata_kept", rd, 32'hAAAA5555);

        // Input hold: addr/wdata scrambled after the accept cycle
        access(0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1, rd, e, rc, sc);
        check("hold_st_ready_cyc", 32'(rc), 32'd5);
        access(0, 1'b0, 32'h30, 32'h0, 1'b1, rd, e, rc, sc);
        check("hold_rdata", rd, 32'hCAFEF00D);

        // Misaligned accesses
        access(0, 1'b1, 32'h08, 32'h0, 1'b0, rd, e, rc, sc);
        access(0, 1'b1, 32'h0A, 32'hFFFFFFFF, 1'b0, rd, e, rc, sc);
        check("mis_st_ready_cyc", 32'(rc), 32'd5);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_st_err",   {31'd0, e}, 32'd1);
        check("mis_st_rdata", rd, 32'd0);
`else
        check("mis_st_err",   {31'd0, e}, 32'd0);
`endif
        access(0, 1'b0, 32'h08, 32'h0, 1'b0, rd, e, rc, sc);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_ld8_rdata", rd, 32'd0);
`else
        check("mis_ld8_rdata", rd, 32'hFFFFFFFF);
`endif
        check("mis_ld8_err", {31'd0, e}, 32'd0);
        access(0, 1'b0, 32'h13, 32'h0, 1'b0, rd, e, rc, sc);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_ld13_rdata", rd, 32'd0);
        check("mis_ld13_err",   {31'd0, e}, 32'd1);
`else
        check("mis_ld13_rdata", rd, 32'hDEADBEEF);
        check("mis_ld13_err",   {31'd0, e}, 32'd0);
`endif

        // Latency sweep: LATENCY=1
        access(1, 1'b1, 32'h44, 32'h0BADF00D, 1'b0, rd, e, rc, sc);
        access(1, 1'b0, 32'h44, 32'h0, 1'b0, rd, e, rc, sc);
        check("lat1_ready_cyc", 32'(rc), 32'd2);
        check("lat1_stall_cnt", 32'(sc), 32'd2);
        check("lat1_rdata",     rd, 32'h0BADF00D);

        // Latency sweep: LATENCY=15
        access(2, 1'b1, 32'h7C, 32'h5A5AA5A5, 1'b0, rd, e, rc, sc);
        access(2, 1'b0, 32'h7C, 32'h0, 1'b0, rd, e, rc, sc);
        check("lat15_ready_cyc", 32'(rc), 32'd16);
        check("lat15_stall_cnt", 32'(sc), 32'd16);
        check("lat15_rdata",     rd, 32'h5A5AA5A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
